// File: rtl/gcd_selfcheck_stimulus.sv
// -----------------------------------------------------------------------------
// gcd_selfcheck_stimulus
//
// Self-checking stimulus generator for a GCD-protocol DUT. A Galois LFSR
// supplies NUM_VECTORS operand pairs. Each pair is handed to the DUT with a
// one-cycle load pulse. An internal subtractive-Euclid engine computes the
// expected GCD in parallel. Every DUT result is compared against it.
// Mismatches and timeouts are counted. At the end the module raises done and
// pass.
//
// Ports
//   clock         in   1      rising-edge clock
//   reset         in   1      synchronous, active-high; aborts and restarts run
//   load          out  1      one-cycle pulse, dataA/dataB valid
//   dataA, dataB  out  WIDTH  operands, held until the next load (never zero)
//   resultReady   in   1      DUT result valid
//   resultData    in   WIDTH  DUT result
//   vectorCount   out  16     vectors completed (checked or timed out)
//   errorCount    out  16     mismatches + timeouts, saturating
//   timeoutCount  out  16     timeouts only, saturating
//   done          out  1      run complete, sticky until reset
//   pass          out  1      done with zero errors
// -----------------------------------------------------------------------------
module gcd_selfcheck_stimulus #(
    parameter int                 WIDTH       = 8,
    parameter int                 NUM_VECTORS = 16,
    parameter int                 TIMEOUT     = 1024,
    parameter logic [2*WIDTH-1:0] SEED        = 16'hACE1,
    parameter logic [2*WIDTH-1:0] POLY        = 16'hB400
) (
    input  logic             clock,
    input  logic             reset,
    output logic             load,
    output logic [WIDTH-1:0] dataA,
    output logic [WIDTH-1:0] dataB,
    input  logic             resultReady,
    input  logic [WIDTH-1:0] resultData,
    output logic [15:0]      vectorCount,
    output logic [15:0]      errorCount,
    output logic [15:0]      timeoutCount,
    output logic             done,
    output logic             pass
);
    localparam int LW = 2 * WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LW-1:0] SEED_NZ  = (SEED == '0) ? LW'(1) : SEED;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   NV       = 16'(NUM_VECTORS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_NEXT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    lfsr_q, lfsr_d;
    logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic [WIDTH-1:0] ref_a_q, ref_a_d, ref_b_q, ref_b_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic             held_vld_q, held_vld_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;

    logic             ref_done;
    logic [LW-1:0]    lfsr_step;
    logic [WIDTH-1:0] op_a, op_b;
    logic             have_result;
    logic [WIDTH-1:0] dut_result;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ref_done  = (ref_a_q == ref_b_q);
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    assign op_a = (lfsr_q[LW-1:WIDTH] == '0) ? WIDTH'(1) : lfsr_q[LW-1:WIDTH];
    assign op_b = (lfsr_q[WIDTH-1:0] == '0) ? WIDTH'(1) : lfsr_q[WIDTH-1:0];

    // A result that arrived before the reference engine finished is held.
    // It stands in for the live input until the comparison happens.
    assign have_result = held_vld_q | resultReady;
    assign dut_result  = held_vld_q ? held_q : resultData;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        ref_a_d    = ref_a_q;
        ref_b_d    = ref_b_q;
        held_d     = held_q;
        held_vld_d = held_vld_q;
        tmo_d      = tmo_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        // Reference engine: one subtraction per cycle until both sides agree.
        if (!ref_done) begin
            if (ref_a_q > ref_b_q) ref_a_d = ref_a_q - ref_b_q;
            else                   ref_b_d = ref_b_q - ref_a_q;
        end

        unique case (state_q)
            S_IDLE: begin
                data_a_d = op_a;
                data_b_d = op_b;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                lfsr_d     = lfsr_step;
                ref_a_d    = data_a_q;
                ref_b_d    = data_b_q;
                tmo_d      = '0;
                held_vld_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (have_result && ref_done) begin
                    if (dut_result != ref_a_q) err_cnt_d = sat_inc(err_cnt_q);
                    state_d = S_NEXT;
                end else if (resultReady && !held_vld_q) begin
                    // A result on the last allowed cycle takes priority over the timeout.
                    held_vld_d = 1'b1;
                    held_d     = resultData;
                end else if (!held_vld_q) begin
                    if (tmo_q == TMO_LAST) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        tmo_cnt_d = sat_inc(tmo_cnt_q);
                        state_d   = S_NEXT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_NEXT: begin
                vec_cnt_d = sat_inc(vec_cnt_q);
                if (vec_cnt_d == NV) begin
                    state_d = S_DONE;
                end else begin
                    data_a_d = op_a;
                    data_b_d = op_b;
                    state_d  = S_LOAD;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED_NZ;
            data_a_q   <= '0;
            data_b_q   <= '0;
            ref_a_q    <= '0;
            ref_b_q    <= '0;
            held_q     <= '0;
            held_vld_q <= 1'b0;
            tmo_q      <= '0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            ref_a_q    <= ref_a_d;
            ref_b_q    <= ref_b_d;
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
            tmo_q      <= tmo_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign load         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign pass         = done && (err_cnt_q == 16'd0);
    assign dataA        = data_a_q;
    assign dataB        = data_b_q;
    assign vectorCount  = vec_cnt_q;
    assign errorCount   = err_cnt_q;
    assign timeoutCount = tmo_cnt_q;

endmodule

// File: tb/tb_gcd_selfcheck_stimulus.sv
// -----------------------------------------------------------------------------
// Testbench for gcd_selfcheck_stimulus.
//
// The bench emulates the DUT side. For each vector it answers with a planned
// latency and value:
//   - correct result
//   - result on the very last allowed cycle
//   - late result, landing in NEXT or LOAD
//   - no answer at all
//   - a stub value of 1
//   - a corrupted value
// The expected operands, GCDs and error/timeout totals come from plain
// arithmetic.
//
// A second instance runs with SEED=0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gcd_selfcheck_stimulus;
    localparam int W     = 8;
    localparam int NV    = 12;
    localparam int TMO   = 16;
    localparam int BOUND = 20000;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset = 1'b1;

    logic         load, done, pass, resultReady;
    logic [W-1:0] dataA, dataB, resultData;
    logic [15:0]  vectorCount, errorCount, timeoutCount;

    logic         load0, done0, pass0, rr0;
    logic [W-1:0] dataA0, dataB0, rd0;
    logic [15:0]  vc0, ec0, tc0;

    gcd_selfcheck_stimulus #(.WIDTH(W), .NUM_VECTORS(NV), .TIMEOUT(TMO)) u_dut (
        .clock(clock), .reset(reset), .load(load), .dataA(dataA), .dataB(dataB),
        .resultReady(resultReady), .resultData(resultData),
        .vectorCount(vectorCount), .errorCount(errorCount),
        .timeoutCount(timeoutCount), .done(done), .pass(pass));

    gcd_selfcheck_stimulus #(.WIDTH(W), .NUM_VECTORS(2), .TIMEOUT(TMO),
                             .SEED(16'h0000)) u_dut0 (
        .clock(clock), .reset(reset), .load(load0), .dataA(dataA0), .dataB(dataB0),
        .resultReady(rr0), .resultData(rd0),
        .vectorCount(vc0), .errorCount(ec0),
        .timeoutCount(tc0), .done(done0), .pass(pass0));

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_a [NV];
    logic [W-1:0] exp_b [NV];
    logic [W-1:0] plan_val [NV];
    int           plan_lat [NV];   // 0 = never answers
    int           exp_err [NV];
    int           exp_tmo [NV];

    int n_loads    = 0;
    bit done_seen  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] nz(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    function automatic logic [2*W-1:0] lfsr_next(input logic [2*W-1:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic make_plan();
        logic [2*W-1:0] s;
        int kind;
        int g;
        s = 16'hACE1;
        for (int k = 0; k < NV; k++) begin
            exp_a[k] = nz(s[2*W-1:W]);
            exp_b[k] = nz(s[W-1:0]);
            s = lfsr_next(s);
            g = gcd_ref(int'(exp_a[k]), int'(exp_b[k]));
            kind = (k < 7) ? k : int'($urandom_range(0, 6));
            case (kind)
                0: begin plan_lat[k] = int'($urandom_range(1, TMO - 1)); plan_val[k] = W'(g); end
                1: begin plan_lat[k] = TMO;     plan_val[k] = W'(g); end
                2: begin plan_lat[k] = TMO + 1; plan_val[k] = '0; end
                3: begin plan_lat[k] = 0;       plan_val[k] = '0; end
                4: begin plan_lat[k] = TMO + 2; plan_val[k] = '0; end
                5: begin plan_lat[k] = int'($urandom_range(1, TMO)); plan_val[k] = W'(1); end
                default: begin
                    plan_lat[k] = int'($urandom_range(1, TMO));
                    plan_val[k] = W'(g) ^ W'(8'h80);
                end
            endcase
            exp_tmo[k] = (plan_lat[k] == 0 || plan_lat[k] > TMO) ? 1 : 0;
            exp_err[k] = (exp_tmo[k] == 1 || int'(plan_val[k]) != g) ? 1 : 0;
        end
    endtask

    // Emulated DUT for the main instance.
    initial begin
        int cnt;
        int vidx;
        logic [W-1:0] cur;
        cnt = -1; vidx = 0; cur = '0;
        resultReady = 1'b0; resultData = '0;
        forever begin
            @(negedge clock); #1;
            resultReady = 1'b0;
            resultData  = W'($urandom);
            if (reset) begin
                cnt = -1; vidx = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        resultReady = 1'b1;
                        resultData  = cur;
                        cnt = -1;
                    end
                end
                if (load && vidx < NV) begin
                    cur = plan_val[vidx];
                    cnt = (plan_lat[vidx] == 0) ? -1 : plan_lat[vidx];
                    vidx++;
                end
            end
        end
    end

    // Emulated correct DUT for the zero-seed instance: fixed 2-cycle latency.
    initial begin
        int c0;
        logic [W-1:0] v0;
        c0 = -1; v0 = '0; rr0 = 1'b0; rd0 = '0;
        forever begin
            @(negedge clock); #1;
            rr0 = 1'b0;
            if (reset) begin
                c0 = -1;
            end else begin
                if (c0 > 0) begin
                    c0--;
                    if (c0 == 0) begin rr0 = 1'b1; rd0 = v0; c0 = -1; end
                end
                if (load0) begin
                    v0 = W'(gcd_ref(int'(dataA0), int'(dataB0)));
                    c0 = 2;
                end
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    initial begin
        int gap;
        int since_rst;
        int ld0;
        int se;
        int st;
        bit prev_load;
        gap = 0; since_rst = 0; ld0 = 0; prev_load = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                n_loads = 0; gap = 0; since_rst = 0; ld0 = 0;
                done_seen = 1'b0; prev_load = 1'b0;
            end else begin
                since_rst++;
                gap++;
                if (since_rst == 1) begin
                    check("rst_load", int'(load), 0);
                    check("rst_dataA", int'(dataA), 0);
                    check("rst_dataB", int'(dataB), 0);
                    check("rst_vectorCount", int'(vectorCount), 0);
                    check("rst_errorCount", int'(errorCount), 0);
                    check("rst_timeoutCount", int'(timeoutCount), 0);
                    check("rst_done", int'(done), 0);
                    check("rst_pass", int'(pass), 0);
                end
                if (since_rst == 2) check("first_load_timing", int'(load), 1);
                if (load) begin
                    check("load_single_cycle", int'(prev_load), 0);
                    if (n_loads < NV) begin
                        se = 0; st = 0;
                        for (int k = 0; k < n_loads; k++) begin
                            se += exp_err[k];
                            st += exp_tmo[k];
                        end
                        check("dataA", int'(dataA), int'(exp_a[n_loads]));
                        check("dataB", int'(dataB), int'(exp_b[n_loads]));
                        check("vectorCount_at_load", int'(vectorCount), n_loads);
                        check("errorCount_at_load", int'(errorCount), se);
                        check("timeoutCount_at_load", int'(timeoutCount), st);
                        check("done_at_load", int'(done), 0);
                        if (n_loads == 0) begin
                            check("v0_dataA_literal", int'(dataA), 'hAC);
                            check("v0_dataB_literal", int'(dataB), 'hE1);
                        end
                        if (n_loads == 1) begin
                            check("v1_dataA_literal", int'(dataA), 'hE2);
                            check("v1_dataB_literal", int'(dataB), 'h70);
                        end
                        if (n_loads > 0) begin
                            if (exp_tmo[n_loads-1] == 1)
                                check("timeout_gap", gap, TMO + 2);
                            else
                                check("min_gap_ok", int'(gap >= 3), 1);
                        end
                    end else begin
                        check("load_count", n_loads + 1, NV);
                    end
                    n_loads++;
                    gap = 0;
                end
                if (!done) check("pass_without_done", int'(pass), 0);
                if (done_seen) check("done_sticky", int'(done), 1);
                if (done && !done_seen) begin
                    done_seen = 1'b1;
                    se = 0; st = 0;
                    for (int k = 0; k < NV; k++) begin
                        se += exp_err[k];
                        st += exp_tmo[k];
                    end
                    check("final_loads", n_loads, NV);
                    check("final_vectorCount", int'(vectorCount), NV);
                    check("final_errorCount", int'(errorCount), se);
                    check("final_timeoutCount", int'(timeoutCount), st);
                    check("final_pass", int'(pass), (se == 0) ? 1 : 0);
                    $display("run done: vectors=%0d errors=%0d timeouts=%0d pass=%0d",
                             vectorCount, errorCount, timeoutCount, pass);
                end
                if (load0) begin
                    if (ld0 == 0) begin
                        check("seed0_dataA", int'(dataA0), 1);
                        check("seed0_dataB", int'(dataB0), 1);
                    end
                    if (ld0 == 1) begin
                        check("seed0_v1_dataA", int'(dataA0), 'hB4);
                        check("seed0_v1_dataB", int'(dataB0), 1);
                    end
                    ld0++;
                end
                if (load) $display("load %0d: A=%02h B=%02h vc=%0d ec=%0d tc=%0d",
                                   n_loads - 1, dataA, dataB, vectorCount,
                                   errorCount, timeoutCount);
            end
            prev_load = load;
        end
    end

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done_seen && t < BOUND) begin
            @(posedge clock);
            t++;
        end
        check({tag, "_done_reached"}, int'(done_seen), 1);
    endtask

    initial begin
        int t;
        make_plan();
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        wait_done("run1");

        // Second run, aborted by a one-cycle reset while vector index 2 waits.
        @(posedge clock); #2 reset = 1'b1;
        make_plan();
        @(posedge clock); #2 reset = 1'b0;
        t = 0;
        while (n_loads < 3 && t < BOUND) begin
            @(posedge clock);
            t++;
        end
        check("reach_vector3", int'(n_loads >= 3), 1);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        make_plan();
        @(posedge clock); #2 reset = 1'b0;
        wait_done("run3");

        t = 0;
        while (!done0 && t < BOUND) begin
            @(posedge clock);
            t++;
        end
        @(negedge clock);
        check("seed0_done", int'(done0), 1);
        check("seed0_pass", int'(pass0), 1);
        check("seed0_vectorCount", int'(vc0), 2);
        check("seed0_errorCount", int'(ec0), 0);
        check("seed0_timeoutCount", int'(tc0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
